// File: rtl/mem_port_arbiter_if.sv
// Memory-port sharing bus between the fetch/load-store requesters, the arbiter and memory.
// The arbiter sits on the slave modport; the requesters and memory together form the master side.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req0_i;
    logic [ADDR_WIDTH-1:0] addr0_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic                  we0_i;
    logic                  ack0_o;

    logic                  req1_i;
    logic [ADDR_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic                  we1_i;
    logic                  ack1_o;

    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  select_o;
    logic                  busy_o;

    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic                  mem_ready_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req0_i, addr0_i, wdata0_i, we0_i,
        input  req1_i, addr1_i, wdata1_i, we1_i,
        input  mem_ready_i, mem_rdata_i,
        output ack0_o, ack1_o, rdata_o, select_o, busy_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output req0_i, addr0_i, wdata0_i, we0_i,
        output req1_i, addr1_i, wdata1_i, we1_i,
        output mem_ready_i, mem_rdata_i,
        input  ack0_o, ack1_o, rdata_o, select_o, busy_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1); one access at a time, acknowledged with a one-cycle pulse.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  select_q;
    logic                  select_d;
    logic                  last_grant_q;
    logic                  last_grant_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic                  any_req;
    logic                  grant_port;
    logic                  on_bus;

    // On a tie the port that was not served last wins; otherwise the lone requester wins.
    always_comb begin
        any_req    = bus.req0_i | bus.req1_i;
        grant_port = (bus.req0_i & bus.req1_i) ? ~last_grant_q : bus.req1_i;
    end

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = grant_port ? BUS1 : BUS0;
                    select_d     = grant_port;
                    last_grant_d = grant_port;
                end
            end
            BUS0, BUS1: begin
                if (bus.mem_ready_i) begin
                    state_d = DONE;
                    rdata_d = bus.mem_rdata_i;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            select_q     <= 1'b0;
            last_grant_q <= 1'b1;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
        end
    end

    // Handshake outputs depend on registered state only; the memory bus follows the select mux.
    assign on_bus          = (state_q == BUS0) || (state_q == BUS1);
    assign bus.mem_req_o   = on_bus;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.ack0_o      = (state_q == DONE) && !select_q;
    assign bus.ack1_o      = (state_q == DONE) && select_q;
    assign bus.select_o    = select_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_addr_o  = select_q ? bus.addr1_i  : bus.addr0_i;
    assign bus.mem_wdata_o = select_q ? bus.wdata1_i : bus.wdata0_i;
    assign bus.mem_we_o    = on_bus & (select_q ? bus.we1_i : bus.we0_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory, all checked every cycle against a transaction model.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    // Transaction-level reference: one access in flight, known only by who owns it
    // and whether memory has answered yet.
    logic          m_act;
    logic          m_rdy;
    logic          m_sel;
    logic          m_last;
    logic [DW-1:0] m_rdata;

    function automatic logic pick_port(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_rdy   <= 1'b0;
            m_sel   <= 1'b0;
            m_last  <= 1'b1;
            m_rdata <= '0;
        end else if (!m_act) begin
            if (bus.req0_i || bus.req1_i) begin
                m_act  <= 1'b1;
                m_rdy  <= 1'b0;
                m_sel  <= pick_port(bus.req0_i, bus.req1_i, m_last);
                m_last <= pick_port(bus.req0_i, bus.req1_i, m_last);
            end
        end else if (!m_rdy) begin
            if (bus.mem_ready_i) begin
                m_rdy   <= 1'b1;
                m_rdata <= bus.mem_rdata_i;
            end
        end else begin
            m_act <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check1("mem_req", bus.mem_req_o, m_act && !m_rdy);
        check1("busy", bus.busy_o, m_act);
        check1("ack0", bus.ack0_o, m_act && m_rdy && !m_sel);
        check1("ack1", bus.ack1_o, m_act && m_rdy && m_sel);
        check1("select", bus.select_o, m_sel);
        check32("rdata", bus.rdata_o, m_rdata);
        check32("mem_addr", bus.mem_addr_o, m_sel ? bus.addr1_i : bus.addr0_i);
        check32("mem_wdata", bus.mem_wdata_o, m_sel ? bus.wdata1_i : bus.wdata0_i);
        check1("mem_we", bus.mem_we_o, (m_act && !m_rdy) && (m_sel ? bus.we1_i : bus.we0_i));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic new_request(input int p);
        if (p == 0) begin
            bus.req0_i   = 1'b1;
            bus.addr0_i  = $urandom;
            bus.wdata0_i = $urandom;
            bus.we0_i    = ($urandom_range(0, 7) == 0);
        end else begin
            bus.req1_i   = 1'b1;
            bus.addr1_i  = $urandom;
            bus.wdata1_i = $urandom;
            bus.we1_i    = ($urandom_range(0, 1) == 0);
        end
    endtask

    task automatic drop_request(input int p);
        if (p == 0) bus.req0_i = 1'b0;
        else        bus.req1_i = 1'b0;
    endtask

    int   ack_port [4];
    int   ack_cyc  [4];
    int   n_acks;
    logic a0, a1, acked;
    logic pend [2];
    int   age  [2];

    initial begin
        bus.req0_i = 0; bus.addr0_i = '0; bus.wdata0_i = '0; bus.we0_i = 0;
        bus.req1_i = 0; bus.addr1_i = '0; bus.wdata1_i = '0; bus.we1_i = 0;
        bus.mem_ready_i = 0; bus.mem_rdata_i = '0;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        check1("rst_mem_req", bus.mem_req_o, 1'b0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check1("rst_ack0", bus.ack0_o, 1'b0);
        check1("rst_ack1", bus.ack1_o, 1'b0);
        check1("rst_select", bus.select_o, 1'b0);
        check32("rst_rdata", bus.rdata_o, 32'h0);
        tick();
        rst = 1'b0;

        // Single fetch, two-cycle memory latency
        bus.req0_i = 1; bus.addr0_i = 32'h0000_0010;
        sample();
        check1("f_idle_req", bus.mem_req_o, 1'b0);
        tick();
        sample();
        check1("f_bus1_req", bus.mem_req_o, 1'b1);
        check32("f_addr", bus.mem_addr_o, 32'h10);
        check1("f_select", bus.select_o, 1'b0);
        tick();
        bus.mem_ready_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        sample();
        check1("f_bus2_req", bus.mem_req_o, 1'b1);
        tick();
        bus.mem_ready_i = 0; bus.mem_rdata_i = 32'h0;
        sample();
        check1("f_ack0", bus.ack0_o, 1'b1);
        check1("f_ack1", bus.ack1_o, 1'b0);
        check1("f_done_req", bus.mem_req_o, 1'b0);
        check32("f_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        tick();
        bus.req0_i = 0;
        sample();
        check1("f_ack0_once", bus.ack0_o, 1'b0);
        check1("f_idle_busy", bus.busy_o, 1'b0);
        check32("f_rdata_hold", bus.rdata_o, 32'hDEAD_BEEF);

        // Continuous tie with zero-wait memory, from a fresh reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_i = 1; bus.addr0_i = 32'h200;
        bus.req1_i = 1; bus.addr1_i = 32'h300;
        bus.mem_ready_i = 1; bus.mem_rdata_i = 32'h5555_0000;
        n_acks = 0;
        for (int i = 0; i < 13; i++) begin
            sample();
            if ((bus.ack0_o || bus.ack1_o) && n_acks < 4) begin
                ack_port[n_acks] = bus.ack1_o ? 1 : 0;
                ack_cyc[n_acks]  = i;
                n_acks++;
            end
            if (i < 12) tick();
        end
        bus.req0_i = 0; bus.req1_i = 0; bus.mem_ready_i = 0;
        check32("alt_count", n_acks, 4);
        if (n_acks == 4) begin
            check32("alt_first_cycle", ack_cyc[0], 2);
            for (int k = 0; k < 4; k++) begin
                check32("alt_port", ack_port[k], k % 2);
                if (k > 0) check32("alt_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
            end
        end

        // Store on port 1 with port 0 idle
        tick();
        bus.req1_i = 1; bus.addr1_i = 32'h100; bus.wdata1_i = 32'h1234_5678; bus.we1_i = 1;
        bus.we0_i = 0;
        sample();
        check1("st_idle_we", bus.mem_we_o, 1'b0);
        tick();
        sample();
        check1("st_req", bus.mem_req_o, 1'b1);
        check1("st_we", bus.mem_we_o, 1'b1);
        check32("st_wdata", bus.mem_wdata_o, 32'h1234_5678);
        check32("st_addr", bus.mem_addr_o, 32'h100);
        check1("st_select", bus.select_o, 1'b1);
        tick();
        bus.mem_ready_i = 1;
        sample();
        check1("st_we2", bus.mem_we_o, 1'b1);
        tick();
        bus.mem_ready_i = 0;
        sample();
        check1("st_ack1", bus.ack1_o, 1'b1);
        check1("st_done_we", bus.mem_we_o, 1'b0);
        tick();
        bus.req1_i = 0; bus.we1_i = 0;
        sample();
        check1("st_ack1_once", bus.ack1_o, 1'b0);

        // Reset in the middle of a port-1 access
        tick();
        bus.req1_i = 1; bus.addr1_i = 32'h104;
        sample();
        tick();
        sample();
        check1("rb_bus_req", bus.mem_req_o, 1'b1);
        check1("rb_bus_sel", bus.select_o, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        check1("rb_async_req", bus.mem_req_o, 1'b0);
        check1("rb_async_busy", bus.busy_o, 1'b0);
        check1("rb_async_sel", bus.select_o, 1'b0);
        check1("rb_async_ack1", bus.ack1_o, 1'b0);
        check32("rb_async_rdata", bus.rdata_o, 32'h0);
        bus.req0_i = 1; bus.addr0_i = 32'h40;
        for (int i = 0; i < 2; i++) begin
            sample();
            check1("rb_hold_ack1", bus.ack1_o, 1'b0);
            tick();
        end
        rst = 1'b0;
        sample();
        check1("rb_rel_ack1", bus.ack1_o, 1'b0);
        tick();
        sample();
        check1("rb_tie_sel", bus.select_o, 1'b0);
        check1("rb_tie_req", bus.mem_req_o, 1'b1);
        check32("rb_tie_addr", bus.mem_addr_o, 32'h40);
        tick();
        bus.mem_ready_i = 1; bus.mem_rdata_i = 32'hCAFE_0001;
        sample();
        tick();
        bus.mem_ready_i = 0;
        sample();
        check1("rb_ack0", bus.ack0_o, 1'b1);
        check1("rb_no_ack1", bus.ack1_o, 1'b0);
        check32("rb_rdata", bus.rdata_o, 32'hCAFE_0001);
        tick();
        bus.req0_i = 0; bus.req1_i = 0;
        sample();
        check1("rb_idle", bus.busy_o, 1'b0);

        // Stray ready in IDLE, then a fetch whose request drops mid-access
        tick();
        bus.mem_ready_i = 1; bus.mem_rdata_i = 32'hBAD0_0000;
        sample();
        check1("sr_busy", bus.busy_o, 1'b0);
        tick();
        bus.mem_ready_i = 0;
        sample();
        check1("sr_busy2", bus.busy_o, 1'b0);
        check1("sr_ack0", bus.ack0_o, 1'b0);
        check32("sr_rdata_kept", bus.rdata_o, 32'hCAFE_0001);
        tick();
        bus.req0_i = 1; bus.addr0_i = 32'h44;
        sample();
        tick();
        bus.req0_i = 0;
        sample();
        check1("dr_req", bus.mem_req_o, 1'b1);
        check32("dr_addr", bus.mem_addr_o, 32'h44);
        tick();
        bus.mem_ready_i = 1; bus.mem_rdata_i = 32'h600D_F00D;
        sample();
        check1("dr_busy", bus.busy_o, 1'b1);
        tick();
        bus.mem_ready_i = 0;
        sample();
        check1("dr_ack0", bus.ack0_o, 1'b1);
        check32("dr_rdata", bus.rdata_o, 32'h600D_F00D);
        tick();
        sample();
        check1("dr_ack0_once", bus.ack0_o, 1'b0);
        check1("dr_idle", bus.busy_o, 1'b0);

        // Randomized requesters and memory
        pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            sample();
            a0 = bus.ack0_o;
            a1 = bus.ack1_o;
            tick();
            bus.mem_ready_i = bus.mem_req_o ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 19) == 0);
            bus.mem_rdata_i = $urandom;
            for (int p = 0; p < 2; p++) begin
                acked = (p == 0) ? a0 : a1;
                if (pend[p]) begin
                    if (acked) begin
                        age[p] = 0;
                        if ($urandom_range(0, 1) == 0) new_request(p);
                        else begin
                            drop_request(p);
                            pend[p] = 0;
                        end
                    end else begin
                        age[p]++;
                        if (age[p] > 200) begin
                            checks++;
                            failures++;
                            $display("FAIL watchdog port=%0d waited=%0d cycles required=ack", p, age[p]);
                            drop_request(p);
                            pend[p] = 0;
                            age[p] = 0;
                        end else if (bus.mem_req_o && (bus.select_o == (p == 1))
                                     && $urandom_range(0, 15) == 0) begin
                            drop_request(p);
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_request(p);
                    pend[p] = 1;
                    age[p] = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
